multicycle_main_ctrl: RTL
=========================

// Module: multicycle_main_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. It sequences each
//  instruction through fetch, decode, execute, memory and writeback states.
//  It replaces the single-cycle combinational main decoder and adds a memory
//  ready handshake, jal link writeback and illegal-opcode trapping.
//  Sits beside the ALU decoder; its alu_op output feeds that decoder.
// PARAMETERS
//  OP_W        6  opcode width
//  ALUOP_W     2  alu_op width
//  EN_JAL      1  1 = jal links PC into $31; 0 = jal is treated as illegal
//  MEM_TIMEOUT 15 max cycles waiting on mem_ready before trap (4-bit counter)
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        synchronous reset, active low
//  op         in   OP_W     opcode from instruction register
//  mem_ready  in   1        memory has accepted the write / returned the read
//  iord       out  1        0 = PC addresses memory, 1 = ALUOut
//  mem_wr     out  1        data memory write strobe
//  ir_wr      out  1        instruction register load
//  pc_wr      out  1        unconditional PC write
//  brnch      out  1        PC write qualified by ALU zero
//  reg_ds     out  2        00 rt, 01 rd, 10 $31
//  mem_reg    out  2        writeback source: 00 ALUOut, 01 mem data, 10 PC
//  reg_wr     out  1        register file write enable
//  alu_src_a  out  1        0 = PC, 1 = reg A
//  alu_src_b  out  2        00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  pc_src     out  2        00 ALUResult, 01 ALUOut, 10 jump target
//  alu_op     out  ALUOP_W  00 add, 01 sub, 10 funct-decoded
//  trap       out  1        one-cycle pulse: illegal opcode or memory timeout
//  state_dbg  out  4        current state encoding
// BEHAVIOUR
//  - Moore FSM. Outputs decode only from the state register. Unlisted outputs are 0.
//  - 4-bit wait counter; clears on every state change.
//  - States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6,
//    ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JAL=12, TRAP=13.
//  - FETCH: ir_wr=mem_ready, pc_wr=mem_ready, alu_src_b=01, alu_op=00.
//    Advance to DECODE only when mem_ready=1; otherwise hold.
//  - DECODE: alu_src_b=11. Branch on op:
//    000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH;
//    001000 -> ADDIEX; 000010 -> JUMP; 000011 -> JAL (EN_JAL=1, else TRAP);
//    any other opcode -> TRAP.
//  - MEMADR: alu_src_a=1, alu_src_b=10. Go to MEMRD if op=100011, else MEMWR.
//  - MEMRD: iord=1. Hold until mem_ready, then go to MEMWB.
//  - MEMWB: reg_wr=1, mem_reg=01, reg_ds=00. Then FETCH.
//  - MEMWR: iord=1, mem_wr=1. mem_wr stays high every cycle until mem_ready; then FETCH.
//  - EXEC: alu_src_a=1, alu_op=10. Then ALUWB.
//  - ALUWB: reg_wr=1, reg_ds=01. Then FETCH.
//  - BRANCH: alu_src_a=1, alu_op=01, brnch=1, pc_src=01. Then FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=10. Then ADDIWB.
//  - ADDIWB: reg_wr=1, reg_ds=00. Then FETCH.
//  - JUMP: pc_wr=1, pc_src=10. Then FETCH.
//  - JAL: reg_wr=1, reg_ds=10, mem_reg=10, pc_wr=1, pc_src=10. Then FETCH.
//    PC already holds PC+4 when JAL is reached.
//  - Wait timeout: in FETCH, MEMRD or MEMWR, if the counter reaches MEMTIMEOUT with
//    mem_ready still 0, go to TRAP.
//  - TRAP: trap=1 and all write enables 0. Then FETCH.
//  - Reset (reset_n=0 at a clock edge) forces state to FETCH and clears the counter.
//    This applies mid-instruction: no write strobe is seen on the following cycle.
//  - Outputs after reset are FETCH outputs: alu_src_b=01, ir_wr and pc_wr follow
//    mem_ready, all others 0.
//  - No illegal state: encodings 14-15 go to FETCH.
// TESTING
//  - R-type (op=000000), mem_ready=1: states 0,1,6,7,0; reg_wr=1 only in cycle 4 with reg_ds=01.
//  - lw with mem_ready low for 3 cycles in MEMRD: 5+3=8 cycles per instruction;
//    iord=1 throughout the MEMRD wait.
//  - sw, mem_ready low for 2 cycles: mem_wr high 3 consecutive cycles, then FETCH.
//  - beq then jal: brnch=1 in BRANCH; JAL has reg_ds=10, mem_reg=10, pc_src=10.
//    With EN_JAL=0, jal produces a trap pulse instead.
//  - op=111111 -> trap=1 for one cycle, no reg_wr/mem_wr/pc_wr; next state is FETCH.
//    Same result for FETCH with mem_ready=0 for 15 cycles.
//  - reset_n=0 while in MEMWR -> next cycle state_dbg=0 and mem_wr=0.

Source files
------------

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, with memory-ready waits and trap handling.
module multicycle_main_ctrl #(
  parameter int unsigned OP_W        = 6,
  parameter int unsigned ALUOP_W     = 2,
  parameter bit          EN_JAL      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               iord,
  output logic               mem_wr,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic               brnch,
  output logic [1:0]         reg_ds,
  output logic [1:0]         mem_reg,
  output logic               reg_wr,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               trap,
  output logic [3:0]         state_dbg
);

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_expired;

  // Trap on the cycle that would complete MEM_TIMEOUT cycles of waiting.
  assign wait_expired = (cnt_q == CNT_LAST) && !mem_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)         state_d = S_DECODE;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = EN_JAL ? S_JAL : S_TRAP;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)         state_d = S_MEMWB;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_MEMWR: begin
        if (mem_ready)         state_d = S_FETCH;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Moore output decode; only FETCH's load strobes look at mem_ready.
  always_comb begin
    iord      = 1'b0;
    mem_wr    = 1'b0;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    brnch     = 1'b0;
    reg_ds    = 2'b00;
    mem_reg   = 2'b00;
    reg_wr    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src    = 2'b00;
    alu_op    = ALU_ADD;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
        alu_src_b = 2'b01;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_wr  = 1'b1;
        mem_reg = 2'b01;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_wr = 1'b1;
        reg_ds = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        brnch     = 1'b1;
        pc_src    = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_wr = 1'b1;
      S_JUMP: begin
        pc_wr  = 1'b1;
        pc_src = 2'b10;
      end
      // PC already holds PC+4 here, so it is the link value.
      S_JAL: begin
        reg_wr  = 1'b1;
        reg_ds  = 2'b10;
        mem_reg = 2'b10;
        pc_wr   = 1'b1;
        pc_src  = 2'b10;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule
